bnn_layer_sched: RTL and testbench
==================================

Name: bnn_layer_sched

Overview:
Inference sequencer for the binary CNN datapath (conv1 -> conv2 -> fc).
- Accepts an image with a valid/ready handshake and blocks acceptance while weight/bias configuration writes are in progress.
- Starts each layer engine in turn and waits for its done pulse.
- Runs a sequential argmax over the 10 fc outputs and presents the winning class with a valid/ready handshake.

Parameters:
FC_W, 17, width of each signed fc output score
N_CLASS, 10, number of fc outputs / classes
TIMEOUT, 1024, max cycles allowed from a layer start to its done (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
cfg_busy  input  1  weight/bias load in progress (kernel_layer or offset_layer nonzero)
image_in_valid  input  1  image present on image bus
image_in_ready  output  1  scheduler can accept an image
img_load  output  1  one-cycle strobe: capture image bus into image memory
conv1_start  output  1  one-cycle start pulse to conv1
conv1_done  input  1  one-cycle completion pulse from conv1
conv2_start  output  1  one-cycle start pulse to conv2
conv2_done  input  1  one-cycle completion pulse from conv2
fc_start  output  1  one-cycle start pulse to fc
fc_done  input  1  one-cycle pulse; fc_out_flat is valid in this cycle
fc_out_flat  input  N_CLASS*FC_W  fc scores, class i at bits [i*FC_W +: FC_W], two's complement
class_out_valid  output  1  class result available
class_out_ready  input  1  consumer accepts result
class_out  output  4  winning class index
busy  output  1  high in any state other than IDLE
err  output  1  sticky layer-timeout flag (optional feature)

Behaviour:
- One clock domain; rst is synchronous and active-high.
- Reset values: state=IDLE; all start pulses 0; class_out_valid=0; class_out=0; busy=0; err=0. A reset mid-inference abandons the run and discards captured scores.
- States and transitions:
  - IDLE -> C1 on acceptance.
  - C1 -> C2 on conv1_done.
  - C2 -> FC on conv2_done.
  - FC -> ARGMAX on fc_done.
  - ARGMAX -> OUT after the 9th compare.
  - OUT -> IDLE on handshake.
- image_in_ready = (state==IDLE) && !cfg_busy (combinational).
- Acceptance at cycle T means image_in_valid && image_in_ready:
  - img_load is high in cycle T (combinational, same condition).
  - conv1_start is high in cycle T+1 only.
- Start pulses are registered and exactly one cycle wide. conv2_start is high in the cycle after conv1_done; fc_start is high in the cycle after conv2_done.
- Done inputs are honoured only in their own layer state, from the cycle after that state's start pulse onward. A done in any other state or cycle is ignored.
- cfg_busy rising while the block is not IDLE has no effect on the sequence.
- fc_done at cycle D:
  - All N_CLASS scores are registered.
  - best_idx=0, best_val=score0, cmp_idx=1.
- ARGMAX runs one compare per cycle, cycles D+1..D+9:
  - If score[cmp_idx] > best_val (signed, strict), update best_idx and best_val.
  - Ties keep the lower index.
- class_out and class_out_valid are registered and rise at D+10.
- class_out and class_out_valid hold stable until class_out_valid && class_out_ready.
- After the handshake at cycle H: state is IDLE at H+1, and image_in_ready may rise at H+1.
- If class_out_ready is already high when valid rises, the handshake happens at D+10 and state is IDLE at D+11.
- A new image can never be accepted while the block is busy; there is no overlap between inferences.

Optional Feature:
Macro SCHED_LAYER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on each start pulse and increments in C1/C2/FC.
  - If it reaches TIMEOUT before the matching done, err is set and stays set until rst.
  - class_out=4'hF, and state goes directly to OUT; class_out_valid is asserted the next cycle.
  - The remaining layers are skipped.
- Not defined: no counter is built, err is tied to 0, and the block waits indefinitely for each done.

Test Plan:
- Reset and acceptance gating:
  - Assert rst for 3 cycles with image_in_valid=1 -> image_in_ready, img_load and all starts stay 0; class_out=0.
  - Release rst with cfg_busy=1 -> image_in_ready stays 0 until cfg_busy=0.
- Nominal run, done latencies 5/7/3:
  - Accept at T -> conv1_start at T+1.
  - conv1_done at T+6 -> conv2_start at T+7.
  - conv2_done at T+14 -> fc_start at T+15.
  - fc_done at T+18 with scores {-3,12,40,-100,7,40,0,1,2,39} -> class_out=2 (tie 2 vs 5 resolves to lower index), valid at T+28.
- Negative scores, all values from -65536..-1, maximum -1 at index 9 -> class_out=9, confirming signed compare.
- Backpressure:
  - Hold class_out_ready=0 for 20 cycles -> class_out and valid stable, image_in_ready=0, a second image_in_valid is ignored.
  - Ready=1 at H -> IDLE and image_in_ready=1 at H+1.
- Spurious done pulses:
  - conv2_done or fc_done pulsed during C1, and conv1_done pulsed in the same cycle as conv1_start -> sequence unaffected, result unchanged.
  - rst asserted during ARGMAX -> busy=0 and class_out_valid=0 the next cycle.
- With SCHED_LAYER_TIMEOUT_EN and TIMEOUT=16, conv2_done never arrives -> err=1, class_out=4'hF, valid 17 cycles after conv2_start, fc_start never asserted.

Source files
------------

// File: rtl/bnn_layer_sched.sv
// rtl/bnn_layer_sched.sv - conv1/conv2/fc sequencer with serial argmax; optional SCHED_LAYER_TIMEOUT_EN layer watchdog
module bnn_layer_sched #(
    parameter int FC_W    = 17,
    parameter int N_CLASS = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_busy,
    input  logic                    image_in_valid,
    output logic                    image_in_ready,
    output logic                    img_load,
    output logic                    conv1_start,
    input  logic                    conv1_done,
    output logic                    conv2_start,
    input  logic                    conv2_done,
    output logic                    fc_start,
    input  logic                    fc_done,
    input  logic [N_CLASS*FC_W-1:0] fc_out_flat,
    output logic                    class_out_valid,
    input  logic                    class_out_ready,
    output logic [3:0]              class_out,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic [2:0] {S_IDLE, S_C1, S_C2, S_FC, S_ARGMAX, S_OUT} state_t;

    state_t r_state, w_state_nxt;
    logic r_conv1_start, r_conv2_start, r_fc_start;
    logic w_conv1_start_nxt, w_conv2_start_nxt, w_fc_start_nxt;
    logic signed [FC_W-1:0] r_score [N_CLASS];
    logic signed [FC_W-1:0] r_best_val;
    logic signed [FC_W-1:0] w_cmp_val;
    logic [3:0] r_best_idx, r_cmp_idx, r_class_out;
    logic r_class_valid;
    logic w_accept, w_c1_done, w_c2_done, w_fc_done;
    logic w_better, w_last_cmp, w_in_layer, w_timeout, w_to_fire;

    assign image_in_ready  = (r_state == S_IDLE) && !cfg_busy && !rst;
    assign w_accept        = image_in_valid && image_in_ready;
    assign img_load        = w_accept;
    assign conv1_start     = r_conv1_start;
    assign conv2_start     = r_conv2_start;
    assign fc_start        = r_fc_start;
    assign class_out_valid = r_class_valid;
    assign class_out       = r_class_out;
    assign busy            = (r_state != S_IDLE);

    // A done coinciding with its own start pulse is too early to be genuine
    assign w_c1_done  = (r_state == S_C1) && !r_conv1_start && conv1_done;
    assign w_c2_done  = (r_state == S_C2) && !r_conv2_start && conv2_done;
    assign w_fc_done  = (r_state == S_FC) && !r_fc_start && fc_done;
    assign w_in_layer = (r_state == S_C1) || (r_state == S_C2) || (r_state == S_FC);

    assign w_cmp_val  = r_score[r_cmp_idx];
    assign w_better   = w_cmp_val > r_best_val;
    assign w_last_cmp = (r_cmp_idx == 4'(N_CLASS - 1));

`ifdef SCHED_LAYER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = w_in_layer && (r_cnt >= CNT_W'(TIMEOUT));
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_conv1_start_nxt || w_conv2_start_nxt || w_fc_start_nxt)
                r_cnt <= '0;
            else if (w_in_layer)
                r_cnt <= r_cnt + 1'b1;
            if (w_to_fire)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_conv1_start_nxt = 1'b0;
        w_conv2_start_nxt = 1'b0;
        w_fc_start_nxt    = 1'b0;
        w_to_fire         = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_nxt       = S_C1;
                w_conv1_start_nxt = 1'b1;
            end
            S_C1: if (w_c1_done) begin
                w_state_nxt       = S_C2;
                w_conv2_start_nxt = 1'b1;
            end else if (w_timeout) begin
                w_state_nxt = S_OUT;
                w_to_fire   = 1'b1;
            end
            S_C2: if (w_c2_done) begin
                w_state_nxt    = S_FC;
                w_fc_start_nxt = 1'b1;
            end else if (w_timeout) begin
                w_state_nxt = S_OUT;
                w_to_fire   = 1'b1;
            end
            S_FC: if (w_fc_done) begin
                w_state_nxt = S_ARGMAX;
            end else if (w_timeout) begin
                w_state_nxt = S_OUT;
                w_to_fire   = 1'b1;
            end
            S_ARGMAX: if (w_last_cmp) w_state_nxt = S_OUT;
            S_OUT: if (r_class_valid && class_out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_conv1_start <= 1'b0;
            r_conv2_start <= 1'b0;
            r_fc_start    <= 1'b0;
            r_best_idx    <= '0;
            r_best_val    <= '0;
            r_cmp_idx     <= '0;
            r_class_out   <= '0;
            r_class_valid <= 1'b0;
            for (int i = 0; i < N_CLASS; i++) r_score[i] <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_conv1_start <= w_conv1_start_nxt;
            r_conv2_start <= w_conv2_start_nxt;
            r_fc_start    <= w_fc_start_nxt;
            if (w_fc_done) begin
                for (int i = 0; i < N_CLASS; i++) r_score[i] <= fc_out_flat[i*FC_W +: FC_W];
                r_best_idx <= '0;
                r_best_val <= fc_out_flat[FC_W-1:0];
                r_cmp_idx  <= 4'd1;
            end else if (r_state == S_ARGMAX) begin
                // Strict greater-than so ties keep the lower index
                if (w_better) begin
                    r_best_idx <= r_cmp_idx;
                    r_best_val <= w_cmp_val;
                end
                r_cmp_idx <= r_cmp_idx + 4'd1;
                if (w_last_cmp) begin
                    r_class_out   <= w_better ? r_cmp_idx : r_best_idx;
                    r_class_valid <= 1'b1;
                end
            end else if (w_to_fire) begin
                r_class_out   <= 4'hF;
                r_class_valid <= 1'b1;
            end else if (r_state == S_OUT && r_class_valid && class_out_ready) begin
                r_class_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bnn_layer_sched.sv
// tb/tb_bnn_layer_sched.sv - table-driven scoreboard bench for bnn_layer_sched
module tb_bnn_layer_sched;
    localparam int FC_W    = 17;
    localparam int N_CLASS = 10;

    logic clk = 1'b0;
    logic rst, cfg_busy, image_in_valid, image_in_ready, img_load;
    logic conv1_start, conv1_done, conv2_start, conv2_done, fc_start, fc_done;
    logic class_out_valid, class_out_ready, busy, err;
    logic [N_CLASS*FC_W-1:0] fc_out_flat;
    logic [3:0] class_out;

    bnn_layer_sched #(.FC_W(FC_W), .N_CLASS(N_CLASS), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cfg_busy(cfg_busy),
        .image_in_valid(image_in_valid), .image_in_ready(image_in_ready), .img_load(img_load),
        .conv1_start(conv1_start), .conv1_done(conv1_done),
        .conv2_start(conv2_start), .conv2_done(conv2_done),
        .fc_start(fc_start), .fc_done(fc_done), .fc_out_flat(fc_out_flat),
        .class_out_valid(class_out_valid), .class_out_ready(class_out_ready),
        .class_out(class_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CLASS*FC_W-1:0] flat;
        int   l1, l2, l3;
        int   rdy_wait;
        bit   spur;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] sb_q[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_c1 = 0, n_c2 = 0, n_fc = 0;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            n_c1 <= n_c1 + int'(conv1_start);
            n_c2 <= n_c2 + int'(conv2_start);
            n_fc <= n_fc + int'(fc_start);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [N_CLASS*FC_W-1:0] pack(input int s[N_CLASS]);
        logic [N_CLASS*FC_W-1:0] r;
        for (int i = 0; i < N_CLASS; i++) r[i*FC_W +: FC_W] = FC_W'(s[i]);
        return r;
    endfunction

    // Raises the chosen done lat cycles after the current (start) cycle
    task automatic wait_done(input int which, input int lat, input logic [N_CLASS*FC_W-1:0] flat, input bit spur);
        if (spur) begin conv1_done = 1'b1; fc_done = 1'b1; end
        for (int k = 1; k < lat; k++) begin
            tick();
            conv1_done = 1'b0; conv2_done = 1'b0; fc_done = 1'b0;
            if (spur && k == 1) conv2_done = 1'b1;
        end
        tick();
        conv1_done = 1'b0; conv2_done = 1'b0; fc_done = 1'b0;
        case (which)
            1: conv1_done = 1'b1;
            2: conv2_done = 1'b1;
            default: begin fc_done = 1'b1; fc_out_flat = flat; end
        endcase
    endtask

    task automatic accept_image();
        int n;
        image_in_valid = 1'b1;
        #1;
        n = 0;
        while (!image_in_ready && n < 50) begin tick(); n++; end
        check("img_load", img_load, 1);
        tick();
        image_in_valid = 1'b0;
        #1;
        check("conv1_start", conv1_start, 1);
        check("busy_run", busy, 1);
    endtask

    task automatic run(input vec_t v, input bit abort);
        int d, n, c1, c2, cf;
        logic [3:0] want;
        c1 = n_c1; c2 = n_c2; cf = n_fc;
        class_out_ready = (v.rdy_wait == 0);
        accept_image();
        wait_done(1, v.l1, v.flat, v.spur);
        tick(); conv1_done = 1'b0; #1;
        check("conv2_start", conv2_start, 1);
        wait_done(2, v.l2, v.flat, 1'b0);
        tick(); conv2_done = 1'b0; #1;
        check("fc_start", fc_start, 1);
        wait_done(3, v.l3, v.flat, 1'b0);
        sb_q.push_back(v.exp);
        d = cyc;
        tick(); fc_done = 1'b0; #1;
        if (abort) begin
            tick(); tick();
            rst = 1'b1;
            tick();
            check("abort_busy", busy, 0);
            check("abort_valid", class_out_valid, 0);
            rst = 1'b0;
            sb_q.delete();
            return;
        end
        n = 0;
        while (!class_out_valid && n < 20) begin tick(); n++; end
        check("valid_latency", cyc - d, 10);
        if (v.rdy_wait > 0) begin
            image_in_valid = 1'b1;
            for (int k = 0; k < v.rdy_wait; k++) begin
                tick();
                check("hold_valid", class_out_valid, 1);
                check("hold_class", class_out, v.exp);
                check("hold_ready", image_in_ready, 0);
                check("hold_img_load", img_load, 0);
            end
            image_in_valid = 1'b0;
            class_out_ready = 1'b1;
            #1;
        end
        check("hs_valid", class_out_valid, 1);
        if (sb_q.size() == 0) check("sb_empty", 1, 0);
        else begin
            want = sb_q.pop_front();
            check("class_out", class_out, want);
        end
        tick();
        class_out_ready = 1'b0;
        #1;
        check("post_busy", busy, 0);
        check("post_ready", image_in_ready, 1);
        check("post_valid", class_out_valid, 0);
        check("n_conv1_start", n_c1 - c1, 1);
        check("n_conv2_start", n_c2 - c2, 1);
        check("n_fc_start", n_fc - cf, 1);
    endtask

    initial begin
        int s[N_CLASS];
        s = '{-3, 12, 40, -100, 7, 40, 0, 1, 2, 39};
        vecs[0] = '{pack(s), 5, 7, 3, 0, 1'b0, 4'd2};
        s = '{-65536, -5, -300, -2, -65535, -100, -7, -3, -2, -1};
        vecs[1] = '{pack(s), 1, 1, 1, 0, 1'b0, 4'd9};
        s = '{65535, -65536, 65534, 0, -1, 100, 65535, 3, 4, 5};
        vecs[2] = '{pack(s), 2, 3, 4, 20, 1'b0, 4'd0};
        s = '{-3, 12, 40, -100, 7, 40, 0, 1, 2, 39};
        vecs[3] = '{pack(s), 5, 7, 3, 0, 1'b1, 4'd2};
        s = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        vecs[4] = '{pack(s), 3, 2, 2, 2, 1'b0, 4'd9};
        s = '{-65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536};
        vecs[5] = '{pack(s), 2, 2, 2, 0, 1'b0, 4'd0};

        rst = 1'b1; cfg_busy = 1'b0; image_in_valid = 1'b1;
        conv1_done = 1'b0; conv2_done = 1'b0; fc_done = 1'b0;
        fc_out_flat = '0; class_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_ready", image_in_ready, 0);
            check("rst_img_load", img_load, 0);
            check("rst_starts", {conv1_start, conv2_start, fc_start}, 0);
            check("rst_class", class_out, 0);
            check("rst_valid", class_out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_err", err, 0);
        end
        image_in_valid = 1'b0; cfg_busy = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("cfg_busy_ready", image_in_ready, 0);
        end
        cfg_busy = 1'b0;
        #1;
        check("cfg_idle_ready", image_in_ready, 1);

        for (int i = 0; i < 6; i++) run(vecs[i], 1'b0);
        run(vecs[0], 1'b1);
        run(vecs[1], 1'b0);

`ifdef SCHED_LAYER_TIMEOUT_EN
        begin
            int sc, cf, n;
            cf = n_fc;
            class_out_ready = 1'b0;
            accept_image();
            wait_done(1, 3, '0, 1'b0);
            tick(); conv1_done = 1'b0; #1;
            check("to_conv2_start", conv2_start, 1);
            sc = cyc;
            n = 0;
            while (!class_out_valid && n < 40) begin tick(); n++; end
            check("to_latency", cyc - sc, 17);
            check("to_class", class_out, 4'hF);
            check("to_err", err, 1);
            check("to_no_fc_start", n_fc - cf, 0);
            class_out_ready = 1'b1;
            tick();
            class_out_ready = 1'b0;
            #1;
            check("to_idle", busy, 0);
        end
`else
        check("err_tied", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
